// File: rtl/ex_stage_pkg.sv
// Shared opcode/funct encodings and types for the MIPS execute stage.
package ex_stage_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpSltiu = 6'h0B;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll   = 6'h00;
  localparam logic [5:0] FnSrl   = 6'h02;
  localparam logic [5:0] FnSra   = 6'h03;
  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu  = 6'h1B;
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [5:0] FnSubu  = 6'h23;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnOr    = 6'h25;
  localparam logic [5:0] FnXor   = 6'h26;
  localparam logic [5:0] FnNor   = 6'h27;
  localparam logic [5:0] FnSlt   = 6'h2A;
  localparam logic [5:0] FnSltu  = 6'h2B;

  // Encoded as funct[1:0] of MULT/MULTU/DIV/DIVU.
  typedef enum logic [1:0] {
    MdMult  = 2'b00,
    MdMultu = 2'b01,
    MdDiv   = 2'b10,
    MdDivu  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } md_state_e;

  function automatic logic is_md_op(logic [31:0] ins);
    return (ins[31:26] == OpRtype) && (ins[5:0] inside {FnMult, FnMultu, FnDiv, FnDivu});
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Decode-to-execute bus: operands in, ALU result and stall out.
interface ex_stage_if;
  logic [31:0] Ins;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic [31:0] Ed32;
  logic [31:0] Result;
  logic        Zero;
  logic        Stall;

  modport master (output Ins, Rdata1, Rdata2, Ed32, input Result, Zero, Stall);
  modport slave  (input Ins, Rdata1, Rdata2, Ed32, output Result, Zero, Stall);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine (one result bit per cycle) owning HI/LO.
module muldiv_unit
  import ex_stage_pkg::*;
#(
  parameter int unsigned MdCycles = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned CntW = $clog2(MdCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(MdCycles - 1);

  md_state_e       st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     acc_q, acc_d;    // partial product high half / remainder
  logic [31:0]     wrk_q, wrk_d;    // multiplier / dividend shifting into quotient
  logic [31:0]     dvsr_q, dvsr_d;  // multiplicand / divisor magnitude
  logic            is_div_q, is_div_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            div_zero_q, div_zero_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;

  logic        signed_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_sh, div_diff;
  logic        div_fit;
  logic [31:0] step_acc, step_wrk;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  assign signed_op = (op == MdMult) || (op == MdDiv);
  assign a_neg     = signed_op & a[31];
  assign b_neg     = signed_op & b[31];
  assign a_mag     = a_neg ? (~a + 32'd1) : a;
  assign b_mag     = b_neg ? (~b + 32'd1) : b;

  // Shift-add multiply step: conditionally add, then shift {acc,wrk} right.
  assign mul_sum  = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, dvsr_q} : 33'd0);
  // Restoring divide step: shift in next dividend bit, subtract if it fits.
  assign div_sh   = {acc_q, wrk_q[31]};
  assign div_diff = div_sh - {1'b0, dvsr_q};
  assign div_fit  = ~div_diff[32];

  assign step_acc = is_div_q ? (div_fit ? div_diff[31:0] : div_sh[31:0]) : mul_sum[32:1];
  assign step_wrk = is_div_q ? {wrk_q[30:0], div_fit} : {mul_sum[0], wrk_q[31:1]};

  assign prod = neg_res_q ? (~{step_acc, step_wrk} + 64'd1) : {step_acc, step_wrk};
  assign quo  = neg_res_q ? (~step_wrk + 32'd1) : step_wrk;
  assign rem  = neg_rem_q ? (~step_acc + 32'd1) : step_acc;

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    wrk_d      = wrk_q;
    dvsr_d     = dvsr_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy       = 1'b0;
    case (st_q)
      StIdle: begin
        if (start) begin
          busy       = 1'b1;
          st_d       = StBusy;
          cnt_d      = '0;
          acc_d      = '0;
          wrk_d      = a_mag;
          dvsr_d     = b_mag;
          is_div_d   = op[1];
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div_zero_d = (b == 32'd0);
        end
      end
      StBusy: begin
        busy  = 1'b1;
        acc_d = step_acc;
        wrk_d = step_wrk;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          st_d = StDone;
          if (is_div_q) begin
            hi_d = rem;
            lo_d = div_zero_q ? 32'hFFFF_FFFF : quo;
          end else begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end
        end
      end
      StDone:  st_d = StIdle;
      default: st_d = StIdle;
    endcase
    if (!RST) busy = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      st_q       <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      wrk_q      <= '0;
      dvsr_q     <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      wrk_q      <= wrk_d;
      dvsr_q     <= dvsr_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: combinational ALU/address path plus the HI/LO mul/div engine.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned MdCycles = 32
) (
  input logic       CLK,
  input logic       RST,
  ex_stage_if.slave bus
);

  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic [31:0] r1, r2, ed;
  logic [31:0] sum_imm, alu;
  logic [31:0] hi, lo;
  logic        md_start, md_busy;
  md_op_e      md_op;

  assign opcode   = bus.Ins[31:26];
  assign funct    = bus.Ins[5:0];
  assign shamt    = bus.Ins[10:6];
  assign r1       = bus.Rdata1;
  assign r2       = bus.Rdata2;
  assign ed       = bus.Ed32;
  assign sum_imm  = r1 + ed;
  assign md_start = is_md_op(bus.Ins);
  assign md_op    = md_op_e'(funct[1:0]);

  muldiv_unit #(
    .MdCycles(MdCycles)
  ) u_muldiv (
    .CLK  (CLK),
    .RST  (RST),
    .start(md_start),
    .op   (md_op),
    .a    (r1),
    .b    (r2),
    .busy (md_busy),
    .HI   (hi),
    .LO   (lo)
  );

  always_comb begin
    alu = sum_imm;
    case (opcode)
      OpRtype: begin
        case (funct)
          FnAdd, FnAddu: alu = r1 + r2;
          FnSub, FnSubu: alu = r1 - r2;
          FnAnd:         alu = r1 & r2;
          FnOr:          alu = r1 | r2;
          FnXor:         alu = r1 ^ r2;
          FnNor:         alu = ~(r1 | r2);
          FnSlt:         alu = {31'd0, $signed(r1) < $signed(r2)};
          FnSltu:        alu = {31'd0, r1 < r2};
          FnSll:         alu = r2 << shamt;
          FnSrl:         alu = r2 >> shamt;
          FnSra:         alu = 32'($signed(r2) >>> shamt);
          FnMfhi:        alu = hi;
          FnMflo:        alu = lo;
          FnJr:          alu = r1;
          default:       alu = r1;
        endcase
      end
      OpAddi, OpAddiu, OpLw, OpSw: alu = sum_imm;
      OpSlti:  alu = {31'd0, $signed(r1) < $signed(ed)};
      OpSltiu: alu = {31'd0, r1 < ed};
      OpAndi:  alu = r1 & ed;
      OpOri:   alu = r1 | ed;
      OpXori:  alu = r1 ^ ed;
      OpLui:   alu = {bus.Ins[15:0], 16'h0000};
      default: alu = sum_imm;
    endcase
  end

  assign bus.Result = RST ? alu : 32'd0;
  assign bus.Zero   = (r1 == r2);
  assign bus.Stall  = md_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: arithmetic reference model checked every cycle plus literal vectors.
module tb_ex_stage;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  ex_stage_if bus ();

  ex_stage #(
    .MdCycles(32)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_md(input logic [31:0] ins);
    return (ins[31:26] == 6'h00) && (ins[5:0] >= 6'h18) && (ins[5:0] <= 6'h1B);
  endfunction

  function automatic logic [31:0] model_alu(input logic [31:0] ins, r1, r2, ed, hi, lo);
    logic [63:0] ext;
    int          sh;
    sh  = int'(ins[10:6]);
    ext = {{32{r2[31]}}, r2} >> sh;
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h20, 6'h21: return r1 + r2;
        6'h22, 6'h23: return r1 - r2;
        6'h24: return r1 & r2;
        6'h25: return r1 | r2;
        6'h26: return r1 ^ r2;
        6'h27: return ~(r1 | r2);
        6'h2A: return ($signed(r1) < $signed(r2)) ? 32'd1 : 32'd0;
        6'h2B: return (r1 < r2) ? 32'd1 : 32'd0;
        6'h00: return r2 << sh;
        6'h02: return r2 >> sh;
        6'h03: return ext[31:0];
        6'h10: return hi;
        6'h12: return lo;
        default: return r1;
      endcase
    end
    case (ins[31:26])
      6'h0A: return ($signed(r1) < $signed(ed)) ? 32'd1 : 32'd0;
      6'h0B: return (r1 < ed) ? 32'd1 : 32'd0;
      6'h0C: return r1 & ed;
      6'h0D: return r1 | ed;
      6'h0E: return r1 ^ ed;
      6'h0F: return {ins[15:0], 16'h0};
      default: return r1 + ed;
    endcase
  endfunction

  // Returns {HI, LO}.
  function automatic logic [63:0] model_md(input logic [31:0] ins, a, b);
    longint      p;
    logic [63:0] u;
    logic [31:0] q, r;
    case (ins[1:0])
      2'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        u = 64'(p);
        return u;
      end
      2'd1: begin
        u = {32'd0, a} * {32'd0, b};
        return u;
      end
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Timeline: issue cycle, 32 busy cycles (stalled), one done cycle, then free.
  int          cyc   = 0;
  int          issue = -1000;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;
  logic [63:0] p_hilo = 64'd0;

  function automatic logic in_window(input int d);
    return (d >= 1) && (d <= 33);
  endfunction

  function automatic logic exp_stall(input int d, input logic rst, input logic [31:0] ins);
    if (!rst) return 1'b0;
    if (d >= 1 && d <= 32) return 1'b1;
    if (d == 33) return 1'b0;
    return is_md(ins);
  endfunction

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!RST) begin
      issue <= -1000;
      m_hi  <= 32'd0;
      m_lo  <= 32'd0;
    end else begin
      if (cyc - issue == 32) begin
        m_hi <= p_hilo[63:32];
        m_lo <= p_hilo[31:0];
      end
      if (!in_window(cyc - issue) && is_md(bus.Ins)) begin
        issue  <= cyc;
        p_hilo <= model_md(bus.Ins, bus.Rdata1, bus.Rdata2);
      end
    end
  end

  always @(negedge CLK) begin
    check("stall", {31'd0, bus.Stall}, {31'd0, exp_stall(cyc - issue, RST, bus.Ins)});
    check("zero", {31'd0, bus.Zero}, {31'd0, bus.Rdata1 == bus.Rdata2});
    if (!RST) check("result_in_reset", bus.Result, 32'd0);
    else if (!is_md(bus.Ins))
      check("result", bus.Result,
            model_alu(bus.Ins, bus.Rdata1, bus.Rdata2, bus.Ed32, m_hi, m_lo));
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 15'h0000, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'h000, imm};
  endfunction

  task automatic drive(input logic [31:0] ins, r1, r2, ed);
    bus.Ins    = ins;
    bus.Rdata1 = r1;
    bus.Rdata2 = r2;
    bus.Ed32   = ed;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic alu_vec(input string name, input logic [31:0] ins, r1, r2, ed, exp);
    drive(ins, r1, r2, ed);
    @(negedge CLK);
    check(name, bus.Result, exp);
    next_cycle();
  endtask

  task automatic mf(input string name, input logic [5:0] fn, input logic [31:0] exp);
    alu_vec(name, rtype(fn, 5'd0), 32'd0, 32'd1, 32'd0, exp);
  endtask

  // Issue a mul/div, count stalled cycles up to the done cycle, then advance.
  task automatic run_md(input string name, input logic [31:0] ins, a, b);
    int n;
    n = 0;
    drive(ins, a, b, 32'd0);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!bus.Stall) break;
      n++;
      next_cycle();
    end
    check(name, 32'(n), 32'd33);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with a MULT on the bus: no stall, zero result.
    drive(rtype(6'h18, 5'd0), 32'hFFFF_FFFD, 32'd7, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check("rst_stall", {31'd0, bus.Stall}, 32'd0);
      check("rst_result", bus.Result, 32'd0);
      next_cycle();
    end
    RST = 1'b1;
    mf("rst_mfhi", 6'h10, 32'd0);
    mf("rst_mflo", 6'h12, 32'd0);

    // ALU and address paths.
    alu_vec("add_wrap", rtype(6'h20, 5'd0), 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h8000_0000);
    alu_vec("addu", rtype(6'h21, 5'd0), 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1);
    alu_vec("sub", rtype(6'h22, 5'd0), 32'd5, 32'd7, 32'd0, 32'hFFFF_FFFE);
    alu_vec("and", rtype(6'h24, 5'd0), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'hF000_F000);
    alu_vec("or", rtype(6'h25, 5'd0), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'hFFF0_FFF0);
    alu_vec("xor", rtype(6'h26, 5'd0), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'h0FF0_0FF0);
    alu_vec("nor", rtype(6'h27, 5'd0), 32'h0F0F_0000, 32'h00FF_0000, 32'd0, 32'hF000_FFFF);
    alu_vec("slt", rtype(6'h2A, 5'd0), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
    alu_vec("sltu", rtype(6'h2B, 5'd0), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    alu_vec("sra", rtype(6'h03, 5'd4), 32'd0, 32'h8000_0000, 32'd0, 32'hF800_0000);
    alu_vec("srl", rtype(6'h02, 5'd4), 32'd0, 32'h8000_0000, 32'd0, 32'h0800_0000);
    alu_vec("sll", rtype(6'h00, 5'd8), 32'd0, 32'h0000_00FF, 32'd0, 32'h0000_FF00);
    alu_vec("jr", rtype(6'h08, 5'd0), 32'hDEAD_BEEF, 32'd3, 32'd0, 32'hDEAD_BEEF);
    alu_vec("lui", itype(6'h0F, 16'h1234), 32'd9, 32'd0, 32'h0000_1234, 32'h1234_0000);
    alu_vec("slti", itype(6'h0A, 16'hFFFF), 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd1);
    alu_vec("sltiu", itype(6'h0B, 16'hFFFF), 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd1);
    alu_vec("andi", itype(6'h0C, 16'hFF00), 32'hFFFF_1234, 32'd0, 32'h0000_FF00, 32'h0000_1200);
    alu_vec("ori", itype(6'h0D, 16'h00F0), 32'h1234_0F0F, 32'd0, 32'h0000_00F0, 32'h1234_0FFF);
    alu_vec("addi", itype(6'h08, 16'hFFFC), 32'h0000_1000, 32'd0, 32'hFFFF_FFFC, 32'h0000_0FFC);
    alu_vec("lw", itype(6'h23, 16'h0010), 32'h0000_1000, 32'd0, 32'h0000_0010, 32'h0000_1010);
    drive(rtype(6'h22, 5'd0), 32'd9, 32'd9, 32'd0);
    @(negedge CLK);
    check("zero_eq", {31'd0, bus.Zero}, 32'd1);
    next_cycle();

    // Multiply / divide.
    run_md("mult_window", rtype(6'h18, 5'd0), 32'hFFFF_FFFD, 32'd7);
    mf("mult_lo", 6'h12, 32'hFFFF_FFEB);
    mf("mult_hi", 6'h10, 32'hFFFF_FFFF);
    run_md("multu_window", rtype(6'h19, 5'd0), 32'hFFFF_FFFF, 32'd2);
    mf("multu_hi", 6'h10, 32'd1);
    mf("multu_lo", 6'h12, 32'hFFFF_FFFE);
    run_md("div_window", rtype(6'h1A, 5'd0), 32'hFFFF_FFF9, 32'd2);
    mf("div_lo", 6'h12, 32'hFFFF_FFFD);
    mf("div_hi", 6'h10, 32'hFFFF_FFFF);
    run_md("div_pos_window", rtype(6'h1A, 5'd0), 32'd7, 32'hFFFF_FFFE);
    mf("div_pos_lo", 6'h12, 32'hFFFF_FFFD);
    mf("div_pos_hi", 6'h10, 32'd1);
    run_md("divu0_window", rtype(6'h1B, 5'd0), 32'd7, 32'd0);
    mf("divu0_lo", 6'h12, 32'hFFFF_FFFF);
    mf("divu0_hi", 6'h10, 32'd7);
    run_md("div0_window", rtype(6'h1A, 5'd0), 32'hFFFF_FFF8, 32'd0);
    mf("div0_hi", 6'h10, 32'hFFFF_FFF8);
    mf("div0_lo", 6'h12, 32'hFFFF_FFFF);
    run_md("divmin_window", rtype(6'h1A, 5'd0), 32'h8000_0000, 32'hFFFF_FFFF);
    mf("divmin_lo", 6'h12, 32'h8000_0000);
    mf("divmin_hi", 6'h10, 32'd0);

    // Reset during busy cycle 10 discards the operation.
    drive(rtype(6'h18, 5'd0), 32'h0001_2345, 32'h0000_0777, 32'd0);
    for (int i = 0; i < 10; i++) next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    check("abort_rst_stall", {31'd0, bus.Stall}, 32'd0);
    next_cycle();
    RST = 1'b1;
    drive(32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge CLK);
    check("abort_stall", {31'd0, bus.Stall}, 32'd0);
    next_cycle();
    mf("abort_hi", 6'h10, 32'd0);
    mf("abort_lo", 6'h12, 32'd0);
    for (int i = 0; i < 30; i++) next_cycle();
    mf("abort_lo_late", 6'h12, 32'd0);

    // Back-to-back: DIVU then MULTU, each with its own stall window.
    run_md("b2b_divu_window", rtype(6'h1B, 5'd0), 32'd100, 32'd7);
    run_md("b2b_multu_window", rtype(6'h19, 5'd0), 32'd3, 32'd5);
    mf("b2b_lo", 6'h12, 32'd15);
    mf("b2b_hi", 6'h10, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the single-cycle MIPS core. It sits directly downstream of the decode stage and consumes Ins, Rdata1, Rdata2 and Ed32. It produces the ALU/address result combinationally. It also owns the HI/LO registers and a 32-iteration multiply/divide engine, and asserts Stall to freeze the PC while that engine is busy.

Parameters:
MD_CYCLES, 32, iterations per multiply/divide (one result bit per cycle)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-low
Ins  in  32  current instruction (held constant by fetch while Stall=1)
Rdata1  in  32  rs value
Rdata2  in  32  rt value
Ed32  in  32  extended immediate (already zero-extended for ANDI/ORI/XORI)
Result  out  32  ALU result / memory address / MFHI-MFLO value
Zero  out  1  Rdata1 == Rdata2, for branch resolution
Stall  out  1  hold PC and Ins this cycle

Behaviour:
- Reset (RST=0 at a rising edge): state<=IDLE, HI<=0, LO<=0, counter<=0. While RST=0, Stall=0 and Result=0. Reset aborts any in-flight multiply/divide; the partial result is discarded.
- Result is combinational, 0-cycle latency.
- R-type (opcode 0x00) by funct:
  - ADD/ADDU 0x20/0x21: wrap-around add.
  - SUB/SUBU 0x22/0x23: wrap-around subtract.
  - AND/OR/XOR/NOR: 0x24 / 0x25 / 0x26 / 0x27.
  - SLT 0x2A (signed compare) and SLTU 0x2B (unsigned compare): result is 0 or 1.
  - SLL/SRL/SRA 0x00/0x02/0x03: shift Rdata2 by Ins[10:6].
  - MFHI 0x10 returns HI; MFLO 0x12 returns LO.
  - JR and all other funct codes: Result=Rdata1.
- No overflow traps; ADD behaves exactly as ADDU.
- I-type:
  - ADDI/ADDIU: Rdata1+Ed32.
  - SLTI signed and SLTIU unsigned compare against Ed32.
  - ANDI/ORI/XORI: apply the operation with Ed32.
  - LUI: {Ins[15:0],16'h0}.
  - LW/SW and all other opcodes: Rdata1+Ed32.
- Multiply/divide FSM, states IDLE, BUSY, DONE:
  - IDLE:
    - Trigger is MULT 0x18, MULTU 0x19, DIV 0x1A or DIVU 0x1B.
    - On a trigger: Stall=1 combinationally the same cycle. At the edge, latch operand magnitudes (signed ops) or raw values (unsigned ops) plus the result sign flags; counter<=0; go to BUSY.
  - BUSY:
    - Stall=1. One shift-add (multiply) or restoring-subtract (divide) step per cycle.
    - When counter==MD_CYCLES-1, write HI/LO at that edge and go to DONE.
  - DONE: Stall=0, so the instruction retires and fetch advances. Always go to IDLE next edge; no re-trigger on the same instruction.
  - Timing: issue cycle 0; Stall=1 for cycles 0..32 (33 cycles); DONE in cycle 33. An MFHI/MFLO in cycle 34 sees the new values.
- Result write rules:
  - Multiply: {HI,LO} = 64-bit product. Signed ops negate the magnitude product when operand signs differ.
  - Divide: LO=quotient, HI=remainder. Quotient is negative when signs differ; remainder takes the dividend's sign.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - Divide by zero (any signedness): HI=Rdata1, LO=0xFFFFFFFF.
- While BUSY, Result still reflects the (held) Ins. Result for a MULT/DIV instruction is don't-care.
- HI/LO change only at the completing edge or at reset.

Decomposition:
- Add the funct constants to common_param.vh alongside the existing opcode constants: ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, MFHI, MFLO, MULT, MULTU, DIV, DIVU, plus LUI, SLTI, SLTIU, ADDIU.
- One sub-module, muldiv_unit:
  - Contains the FSM, counter, datapath and HI/LO registers.
  - Interface: CLK, RST, start, op[1:0], a, b → busy, HI, LO.
  - ex_stage holds the combinational ALU and muxes.

Test Plan:
- Reset: RST=0 for 2 cycles, Ins=MULT → Stall=0, Result=0. After release, MFHI/MFLO return 0.
- ALU: ADD 0x7FFFFFFF+1 → 0x80000000. SLT -1<1 → 1. SLTU 0xFFFFFFFF<1 → 0. SRA 0x80000000 by 4 → 0xF8000000. LUI 0x1234 → 0x12340000.
- MULT Rdata1=-3, Rdata2=7:
  - Stall=1 for exactly 33 cycles, then 0 for 1 cycle.
  - A following MFLO returns 0xFFFFFFEB; MFHI returns 0xFFFFFFFF.
  - MULTU 0xFFFFFFFF×2 gives HI=1, LO=0xFFFFFFFE.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → LO=0xFFFFFFFF, HI=7.
- Reset asserted at BUSY cycle 10 of a MULT → next cycle Stall=0 (Ins changed to NOP), HI=LO=0, state IDLE.
- Back-to-back: DIVU immediately followed by MULTU → second op starts the cycle after DONE. Each op shows a separate 33-cycle stall window; the first op's results are visible before the second completes.
